// File: rtl/ulam_sweep_ctrl_if.sv
// Datapath-side bundle between the sweep sequencer and one Ulam iteration datapath.
// Latency: wires only; the sequencer registers everything it drives.
// Backpressure: none; the datapath answers with a dp_done pulse when it converges.
interface ulam_sweep_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic             dp_clear;
   logic [WIDTH-1:0] dp_seed;
   logic             dp_run;
   logic             dp_done;
   logic [CNT_W-1:0] dp_steps;

   // Sequencer side
   modport master (
      output dp_clear, dp_seed, dp_run,
      input  dp_done, dp_steps
   );

   // Datapath side
   modport slave (
      input  dp_clear, dp_seed, dp_run,
      output dp_done, dp_steps
   );
endinterface

// File: rtl/ulam_sweep_ctrl.sv
// Sweeps seeds first..last through one Ulam datapath, keeping the longest-running seed.
// Latency: 1 LOAD cycle per seed plus the datapath's run time; finished 1 cycle after the last done.
// Backpressure: none; a per-seed watchdog ends the sweep if dp_done never arrives.
module ulam_sweep_ctrl #(
   parameter int WIDTH    = 16,
   parameter int CNT_W    = 16,
   parameter int WD_LIMIT = 1024
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] last,
   input  logic             abort,
   ulam_sweep_ctrl_if.master dp,
   output logic             busy,
   output logic             finished,
   output logic [WIDTH-1:0] best_seed,
   output logic [CNT_W-1:0] best_steps,
   output logic             alert,
   output logic [WIDTH-1:0] alert_seed
);
   localparam int WD_W = $clog2(WD_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] cur, cur_nxt, last_q;
   logic [WD_W-1:0]  wd_cnt;
   logic             wd_hit;
   logic             take_start, seed_done, wd_trip;

   // wd_cnt holds the number of RUN cycles already finished for this seed
   assign wd_hit = (wd_cnt == WD_W'(WD_LIMIT - 1));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and per-cycle events; abort overrides done and watchdog
   always_comb begin
      state_nxt  = state;
      cur_nxt    = cur;
      take_start = 1'b0;
      seed_done  = 1'b0;
      wd_trip    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               take_start = 1'b1;
               cur_nxt    = first;
               state_nxt  = (first == '0 || first > last) ? FINISH : LOAD;
            end
         end
         LOAD: state_nxt = RUN;
         RUN: begin
            if (dp.dp_done) begin
               seed_done = 1'b1;
               // compare before incrementing so an all-ones last seed never wraps
               if (cur == last_q) begin
                  state_nxt = FINISH;
               end else begin
                  state_nxt = LOAD;
                  cur_nxt   = cur + WIDTH'(1);
               end
            end else if (wd_hit) begin
               wd_trip   = 1'b1;
               state_nxt = FINISH;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         cur_nxt   = cur;
         seed_done = 1'b0;
         wd_trip   = 1'b0;
      end
   end

   // Seed tracking, results, watchdog and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur         <= '0;
         last_q      <= '0;
         wd_cnt      <= '0;
         best_seed   <= '0;
         best_steps  <= '0;
         alert       <= 1'b0;
         alert_seed  <= '0;
         busy        <= 1'b0;
         finished    <= 1'b0;
         dp.dp_clear <= 1'b0;
         dp.dp_run   <= 1'b0;
         dp.dp_seed  <= '0;
      end else begin
         cur <= cur_nxt;
         if (take_start) begin
            last_q     <= last;
            best_seed  <= '0;
            best_steps <= '0;
            alert      <= 1'b0;
         end
         // strict compare: on a tie the earlier seed keeps the title
         if (seed_done && dp.dp_steps > best_steps) begin
            best_seed  <= cur;
            best_steps <= dp.dp_steps;
         end
         if (wd_trip) begin
            alert      <= 1'b1;
            alert_seed <= cur;
         end
         if (state == LOAD)     wd_cnt <= '0;
         else if (state == RUN) wd_cnt <= wd_cnt + WD_W'(1);
         dp.dp_clear <= (state_nxt == LOAD);
         dp.dp_run   <= (state_nxt == RUN);
         busy        <= (state_nxt != IDLE);
         finished    <= (state_nxt == FINISH);
         if (state_nxt == LOAD) dp.dp_seed <= cur_nxt;
      end
   end
endmodule

// File: tb/tb_ulam_sweep_ctrl.sv
// Scoreboard bench: three sequencers (long watchdog, short watchdog, 4-bit seeds)
// share one behavioural Collatz datapath; expected sweeps come from a plain-arithmetic model.
module tb_ulam_sweep_ctrl;
   logic clock = 1'b0;
   logic rst;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   logic [2:0]  start_v;
   logic [15:0] first_b, last_b;
   logic        abort_b;
   logic        dp_done;
   logic [15:0] dp_steps;
   int          sel;

   logic        busy_v[3], fin_v[3], alert_v[3], clr_v[3], run_v[3];
   logic [15:0] bseed_v[3], bsteps_v[3], aseed_v[3], seed_v[3];
   logic [3:0]  c_bseed, c_aseed;

   ulam_sweep_ctrl_if #(.WIDTH(16), .CNT_W(16)) ifa ();
   ulam_sweep_ctrl_if #(.WIDTH(16), .CNT_W(16)) ifb ();
   ulam_sweep_ctrl_if #(.WIDTH(4),  .CNT_W(16)) ifc ();

   assign ifa.dp_done = dp_done;  assign ifa.dp_steps = dp_steps;
   assign ifb.dp_done = dp_done;  assign ifb.dp_steps = dp_steps;
   assign ifc.dp_done = dp_done;  assign ifc.dp_steps = dp_steps;

   ulam_sweep_ctrl #(.WIDTH(16), .CNT_W(16), .WD_LIMIT(1024)) u_a (
      .clock(clock), .reset(rst), .start(start_v[0]), .first(first_b), .last(last_b),
      .abort(abort_b), .dp(ifa), .busy(busy_v[0]), .finished(fin_v[0]),
      .best_seed(bseed_v[0]), .best_steps(bsteps_v[0]), .alert(alert_v[0]), .alert_seed(aseed_v[0]));
   ulam_sweep_ctrl #(.WIDTH(16), .CNT_W(16), .WD_LIMIT(8)) u_b (
      .clock(clock), .reset(rst), .start(start_v[1]), .first(first_b), .last(last_b),
      .abort(abort_b), .dp(ifb), .busy(busy_v[1]), .finished(fin_v[1]),
      .best_seed(bseed_v[1]), .best_steps(bsteps_v[1]), .alert(alert_v[1]), .alert_seed(aseed_v[1]));
   ulam_sweep_ctrl #(.WIDTH(4), .CNT_W(16), .WD_LIMIT(1024)) u_c (
      .clock(clock), .reset(rst), .start(start_v[2]), .first(first_b[3:0]), .last(last_b[3:0]),
      .abort(abort_b), .dp(ifc), .busy(busy_v[2]), .finished(fin_v[2]),
      .best_seed(c_bseed), .best_steps(bsteps_v[2]), .alert(alert_v[2]), .alert_seed(c_aseed));

   assign clr_v[0] = ifa.dp_clear;  assign run_v[0] = ifa.dp_run;  assign seed_v[0] = ifa.dp_seed;
   assign clr_v[1] = ifb.dp_clear;  assign run_v[1] = ifb.dp_run;  assign seed_v[1] = ifb.dp_seed;
   assign clr_v[2] = ifc.dp_clear;  assign run_v[2] = ifc.dp_run;  assign seed_v[2] = {12'd0, ifc.dp_seed};
   assign bseed_v[2] = {12'd0, c_bseed};
   assign aseed_v[2] = {12'd0, c_aseed};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] outs(input int i);
      return {59'd0, busy_v[i], fin_v[i], clr_v[i], run_v[i], seed_v[i],
              bseed_v[i], bsteps_v[i], alert_v[i], aseed_v[i]};
   endfunction

   // Collatz step count by direct iteration
   function automatic int csteps(input int n);
      longint v;
      int     s;
      v = n;
      s = 0;
      while (v > 1) begin
         if (v[0]) v = 3 * v + 1;
         else      v = v / 2;
         s++;
      end
      return s;
   endfunction

   typedef struct {
      int          fin_cyc;
      int          nclr;
      logic [15:0] bseed;
      logic [15:0] bsteps;
      logic        alert;
      logic [15:0] aseed;
   } exp_t;

   exp_t        res_q[$];
   logic [15:0] seed_q[$];
   logic [15:0] held_aseed[3];
   logic [15:0] last_loaded[3];
   int          clr_cnt;
   int          fin_seen = 0;

   // Reference sweep: walk the seed range, accumulate cycles and results
   task automatic push_sweep(input int i, input int f, input int l, output int fcyc);
      exp_t e;
      int   wd, bs, t, st;
      wd = (i == 1) ? 8 : 1024;
      e.nclr = 0; e.bseed = 16'd0; e.bsteps = 16'd0; e.alert = 1'b0;
      bs = 0;
      fcyc = 0;
      if (!(f == 0 || f > l)) begin
         for (int s = f; s <= l; s++) begin
            seed_q.push_back(s[15:0]);
            last_loaded[i] = s[15:0];
            e.nclr++;
            st = csteps(s);
            t  = (st < 1) ? 1 : st;
            if (t > wd) begin
               e.alert       = 1'b1;
               held_aseed[i] = s[15:0];
               fcyc += 1 + wd;
               break;
            end
            fcyc += 1 + t;
            if (st > bs) begin
               bs       = st;
               e.bseed  = s[15:0];
               e.bsteps = st[15:0];
            end
         end
      end
      fcyc += 1;
      e.aseed   = held_aseed[i];
      e.fin_cyc = cyc + fcyc;
      res_q.push_back(e);
   endtask

   // Behavioural datapath: done after max(steps,1) RUN cycles; noise on dp_done during LOAD
   int rc, tgt_cur, st_cur;
   initial begin
      dp_done  = 1'b0;
      dp_steps = 16'd0;
      rc = 0; tgt_cur = 1; st_cur = 0;
      forever begin
         @(posedge clock);
         #1;
         if (clr_v[sel]) begin
            st_cur   = csteps(int'(seed_v[sel]));
            tgt_cur  = (st_cur < 1) ? 1 : st_cur;
            rc       = 0;
            dp_done  = ($urandom_range(0, 1) == 1);
            dp_steps = 16'hffff;
         end else if (run_v[sel]) begin
            rc++;
            dp_done  = (rc == tgt_cur);
            dp_steps = (rc == tgt_cur) ? st_cur[15:0] : 16'($urandom);
         end else begin
            dp_done  = 1'b0;
            dp_steps = 16'd0;
         end
      end
   end

   // Monitor: check every load against the seed queue, every finish against the result queue
   logic [15:0] mon_s;
   exp_t        mon_e;
   always @(negedge clock) begin
      if (!rst) begin
         if (clr_v[sel]) begin
            clr_cnt++;
            if (seed_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL load: unexpected dp_clear with seed %0d at cycle %0d", seed_v[sel], cyc);
            end else begin
               mon_s = seed_q.pop_front();
               chk("dp_seed", 128'(seed_v[sel]), 128'(mon_s));
            end
            chk("clear_with_run", 128'(run_v[sel]), 128'(0));
         end
         if (fin_v[sel]) begin
            if (res_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL finish: unexpected finished pulse at cycle %0d", cyc);
            end else begin
               mon_e = res_q.pop_front();
               chk("fin_cycle",  128'(cyc),            128'(mon_e.fin_cyc));
               chk("best_seed",  128'(bseed_v[sel]),   128'(mon_e.bseed));
               chk("best_steps", 128'(bsteps_v[sel]),  128'(mon_e.bsteps));
               chk("alert",      128'(alert_v[sel]),   128'(mon_e.alert));
               chk("alert_seed", 128'(aseed_v[sel]),   128'(mon_e.aseed));
               chk("n_loads",    128'(clr_cnt),        128'(mon_e.nclr));
               chk("loads_left", 128'(seed_q.size()),  128'(0));
               fin_seen++;
            end
         end
      end
   end

   task automatic run_sweep(input int i, input int f, input int l);
      int fc, tgt;
      sel     = i;
      clr_cnt = 0;
      @(posedge clock); #1;
      first_b    = f[15:0];
      last_b     = l[15:0];
      start_v[i] = 1'b1;
      push_sweep(i, f, l, fc);
      tgt = fin_seen + 1;
      @(posedge clock); #1;
      start_v[i] = 1'b0;
      for (int k = 0; k < 4000 && fin_seen < tgt; k++) @(posedge clock);
      chk("finish_seen", 128'(fin_seen >= tgt), 128'(1));
      @(negedge clock);
      chk("busy_after", 128'(busy_v[i]), 128'(0));
      chk("dp_seed_hold", 128'(seed_v[i]), 128'(last_loaded[i]));
   endtask

   // Start sweep 1..7 on the long-watchdog unit and wait until seed s is running
   task automatic start_and_reach(input int s);
      sel = 0; clr_cnt = 0;
      for (int k = 1; k <= 7; k++) seed_q.push_back(k[15:0]);
      @(posedge clock); #1;
      first_b = 16'd1; last_b = 16'd7; start_v[0] = 1'b1;
      @(posedge clock); #1;
      start_v[0] = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (run_v[0] && seed_v[0] == s[15:0]) break;
         @(posedge clock); #1;
      end
      chk("reach_seed", 128'(run_v[0] && seed_v[0] == s[15:0]), 128'(1));
   endtask

   initial begin
      int f, l, i, bs, bseed;
      rst = 1'b1; start_v = 3'b000; abort_b = 1'b0; sel = 0;
      first_b = 16'd0; last_b = 16'd0; clr_cnt = 0;
      for (int k = 0; k < 3; k++) begin held_aseed[k] = 16'd0; last_loaded[k] = 16'd0; end
      repeat (2) @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 3; k++) chk("reset_outputs", outs(k), 128'(0));
      @(posedge clock); #1;
      rst = 1'b0;

      run_sweep(0, 1, 7);      // best 7 / 16
      run_sweep(0, 12, 13);    // tie: 12 wins
      run_sweep(1, 6, 7);      // seed 7 trips the short watchdog
      run_sweep(1, 1, 5);      // alert cleared, alert_seed held
      run_sweep(0, 5, 3);      // range error
      run_sweep(0, 0, 9);      // zero first seed
      run_sweep(2, 15, 15);    // all-ones last seed on a 4-bit unit
      repeat (5) @(posedge clock);

      // abort during seed 3: immediate idle, results from seeds 1..2 held
      start_and_reach(3);
      @(posedge clock); #1;
      @(posedge clock); #1;
      abort_b = 1'b1;
      @(posedge clock); #1;
      abort_b = 1'b0;
      @(negedge clock);
      bs = 0; bseed = 0;
      for (int s = 1; s <= 2; s++) if (csteps(s) > bs) begin bs = csteps(s); bseed = s; end
      chk("abort_busy",       128'(busy_v[0]),  128'(0));
      chk("abort_run",        128'(run_v[0]),   128'(0));
      chk("abort_best_seed",  128'(bseed_v[0]), 128'(bseed));
      chk("abort_best_steps", 128'(bsteps_v[0]), 128'(bs));
      chk("abort_alert",      128'(alert_v[0]), 128'(0));
      seed_q.delete();
      last_loaded[0] = 16'd3;
      repeat (20) @(posedge clock);

      // randomized sweeps across all three units
      for (int r = 0; r < 18; r++) begin
         i = $urandom_range(0, 2);
         if (i == 2) begin
            f = $urandom_range(0, 15);
            l = $urandom_range(0, 15);
         end else begin
            f = $urandom_range(0, 60);
            l = f + $urandom_range(0, 8) - 2;
            if (l < 0) l = 0;
         end
         run_sweep(i, f, l);
      end

      // reset in the middle of a RUN phase
      start_and_reach(4);
      #3;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) chk("midrun_reset_outputs", outs(k), 128'(0));
      seed_q.delete();
      res_q.delete();
      for (int k = 0; k < 3; k++) begin held_aseed[k] = 16'd0; last_loaded[k] = 16'd0; end
      @(posedge clock); #1;
      rst = 1'b0;
      run_sweep(0, 3, 6);

      repeat (5) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ulam_sweep_ctrl.md
# ulam_sweep_ctrl

Sequencer that drives the Ulam (Collatz) iteration datapath across an inclusive range of seeds. It loads each seed, runs the datapath until it reports convergence, and tracks the seed with the longest step count. A per-seed watchdog aborts the sweep when the datapath fails to converge in time. It sits between the host/top-level start logic and a single iteration datapath.

## Interface

Parameters:
- WIDTH, 16, seed width in bits
- CNT_W, 16, step-count width in bits
- WD_LIMIT, 1024, maximum RUN cycles allowed per seed (≥1)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to 0
- start  in  1  level sampled in IDLE; begins a sweep; ignored when not in IDLE
- first  in  WIDTH  first seed, sampled with start
- last  in  WIDTH  last seed (inclusive), sampled with start
- abort  in  1  stops the sweep immediately
- dp_done  in  1  datapath reached 1 for the current seed
- dp_steps  in  CNT_W  step count, valid when dp_done=1
- dp_clear  out  1  one-cycle pulse: datapath loads dp_seed
- dp_seed  out  WIDTH  current seed
- dp_run  out  1  datapath iterates while high
- busy  out  1  high in any state except IDLE
- finished  out  1  one-cycle pulse at sweep end
- best_seed  out  WIDTH  seed with the largest step count so far
- best_steps  out  CNT_W  that seed's step count
- alert  out  1  sticky watchdog flag; cleared by the next accepted start
- alert_seed  out  WIDTH  seed that tripped the watchdog

## Operation

- States: IDLE, LOAD, RUN, FINISH.
- IDLE:
  - On start, latch first/last, clear best_seed, best_steps and alert.
  - If first==0 or first>last, go to FINISH with no datapath activity and results left at 0.
  - Otherwise set cur=first and go to LOAD.
- LOAD:
  - dp_clear=1, dp_seed=cur, watchdog counter cleared.
  - Go to RUN. dp_done is ignored in this state.
- RUN:
  - dp_run=1; the watchdog increments every cycle.
  - On dp_done: if dp_steps > best_steps (strict, so the earliest seed wins ties), update best_seed=cur and best_steps=dp_steps.
  - After dp_done: if cur==last go to FINISH, else cur=cur+1 and go to LOAD.
  - The cur==last comparison happens before incrementing, so last = 2^WIDTH−1 never wraps.
  - If WD_LIMIT RUN cycles elapse without dp_done: alert=1, alert_seed=cur, go to FINISH. Results keep their pre-trip values.
- FINISH: finished=1 for one cycle, then IDLE.
- abort in any non-IDLE state: go to IDLE next edge, with no finished pulse. Results and alert hold their current values.
- Priority on the same edge: reset > abort > dp_done > watchdog expiry.
- dp_seed holds its last value in IDLE. best_* and alert hold until the next accepted start.

## Timing

- Reset value of every output is 0.
- Start accepted at edge 0 → LOAD in cycle 1 (dp_clear=1, dp_seed=first) → RUN from cycle 2.
- dp_done sampled in RUN cycle k:
  - best_* are updated at that edge.
  - The next cycle is LOAD for the next seed, or FINISH.
- Per-seed overhead is exactly 1 LOAD cycle.
- finished is high one cycle after the last dp_done. busy drops the cycle after finished.
- Watchdog: dp_done is accepted in RUN cycles 1..WD_LIMIT. If there is no done by the end of RUN cycle WD_LIMIT, alert rises at the following edge together with FINISH.
- dp_run and dp_clear are registered outputs, never asserted in the same cycle.

## Test plan

- Bench datapath model asserts dp_done with Collatz steps (1:0, 2:1, 3:7, 4:2, 5:5, 6:8, 7:16) after max(steps,1) cycles. Sweep first=1, last=7, WD_LIMIT=1024 → finished pulse, best_seed=7, best_steps=16, alert=0, seven dp_clear pulses.
- Tie: first=12, last=13 (9 steps each) → best_seed=12, best_steps=9.
- Watchdog: WD_LIMIT=8, first=6, last=7 → seed 6 (8 steps) completes. Seed 7 trips → alert=1, alert_seed=7, best_seed=6, best_steps=8, finished pulse.
- Range errors:
  - first=5, last=3 → finished 1 cycle after start, no dp_clear, best_*=0.
  - first=0 → same response.
- Abort in RUN during seed 3 of a 1..7 sweep → IDLE next edge, dp_run=0, no finished pulse. Best values hold (best_seed=2, best_steps=1 if seeds 1..2 completed).
- Wrap: WIDTH=4, first=last=15 → one seed loaded, FINISH reached, no second LOAD.
- Reset asserted mid-RUN → all outputs 0 immediately, state IDLE.
